// File: rtl/spi_master_mmio.sv
// Memory-mapped SPI master (Mode 0, MSB first, 8-bit full duplex).
// Four word registers at BASE_ADDR: TXDATA, RXDATA, STATUS, DIV.
// Register reads are combinational so a CPU load completes in one cycle.
//
// Bus handshake: there is no valid/ready pair. bus_sel is the valid
// qualifier and the slave is always ready. A store (bus_we=1) takes
// effect at the clock edge that ends the bus_sel cycle. A load
// (bus_we=0) returns bus_rdata in the same cycle, and any read side
// effect (clearing rx_valid or ovr) lands at that same edge.
module spi_master_mmio #(
  parameter int unsigned    W_CPU     = 32,
  parameter logic [W_CPU-1:0] BASE_ADDR = 32'h0000_1000,
  parameter logic [7:0]     DIV_RST   = 8'd3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bus_sel,
  input  logic             bus_we,
  input  logic [W_CPU-1:0] bus_addr,
  input  logic [W_CPU-1:0] bus_wdata,
  output logic [W_CPU-1:0] bus_rdata,
  output logic             spi_sclk,
  output logic             spi_mosi,
  input  logic             spi_miso,
  output logic             spi_cs_n,
  output logic             irq,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q;       // cycles spent in the current half-period
  logic [3:0] half_q;      // half-period index within XFER, 0..15
  logic [7:0] shift_q;     // TX bits leave from bit7, RX bits enter at bit0
  logic       samp_q;      // miso captured on the rising sclk edge
  logic [7:0] div_lat_q;   // DIV copy frozen for the active transfer
  logic [7:0] div_q;
  logic [7:0] rxdata_q;
  logic       rx_valid_q;
  logic       ovr_q;
  logic       busy;

  // Address decode and per-register strobes
  logic       hit;
  logic [1:0] off;
  logic       tx_wr, div_wr, rx_rd, st_rd;
  logic       tick, done;

  assign hit    = bus_sel && (bus_addr[W_CPU-1:4] == BASE_ADDR[W_CPU-1:4]);
  assign off    = bus_addr[3:2];
  assign tx_wr  = hit && bus_we  && (off == 2'd0);
  assign div_wr = hit && bus_we  && (off == 2'd3);
  assign rx_rd  = hit && !bus_we && (off == 2'd1);
  assign st_rd  = hit && !bus_we && (off == 2'd2);
  assign tick   = (cnt_q == div_lat_q);
  assign done   = (state_q == ST_HOLD) && tick;

  // Byte lanes and low address bits the register map does not use
  logic unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[W_CPU-1:8]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: SETUP h cycles, XFER 16 half-periods, HOLD h cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (tx_wr) state_d = ST_SETUP;
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER:  if (tick && (half_q == 4'd15)) state_d = ST_HOLD;
      ST_HOLD:  if (tick) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: sclk is high on even XFER half-periods (the odd ones counting from 1)
  always_comb begin
    busy      = (state_q != ST_IDLE);
    spi_cs_n  = !busy;
    spi_sclk  = (state_q == ST_XFER) && !half_q[0];
    spi_mosi  = busy ? shift_q[7] : 1'b0;
    dbg_state = state_q;
  end

  // Datapath: timing counters, shift register, and the register file
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 8'd0;
      half_q     <= 4'd0;
      shift_q    <= 8'd0;
      samp_q     <= 1'b0;
      div_lat_q  <= 8'd0;
      div_q      <= DIV_RST;
      rxdata_q   <= 8'd0;
      rx_valid_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      if (div_wr) div_q <= bus_wdata[7:0];

      case (state_q)
        ST_IDLE: begin
          if (tx_wr) begin
            shift_q   <= bus_wdata[7:0];
            div_lat_q <= div_q;
            cnt_q     <= 8'd0;
            half_q    <= 4'd0;
          end
        end
        ST_SETUP: begin
          cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
          // First rising sclk edge happens as SETUP ends
          if (tick) samp_q <= spi_miso;
        end
        ST_XFER: begin
          cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
          if (tick) begin
            half_q <= half_q + 4'd1;
            if (!half_q[0]) begin
              // High phase ends: falling edge, shift in the sampled bit
              shift_q <= {shift_q[6:0], samp_q};
            end else if (half_q != 4'd15) begin
              // Low phase ends: rising edge, sample miso
              samp_q <= spi_miso;
            end
          end
        end
        ST_HOLD: begin
          cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
        end
        default: ;
      endcase

      // A completion wins over a concurrent RXDATA read
      if (done) begin
        rxdata_q   <= shift_q;
        rx_valid_q <= 1'b1;
      end else if (rx_rd) begin
        rx_valid_q <= 1'b0;
      end

      // A rejected TXDATA write wins over a concurrent STATUS read
      if (tx_wr && busy)  ovr_q <= 1'b1;
      else if (st_rd)     ovr_q <= 1'b0;
    end
  end

  // Combinational read mux; zero when not a load to this window
  always_comb begin
    bus_rdata = '0;
    if (hit && !bus_we) begin
      case (off)
        2'd1:    bus_rdata[7:0] = rxdata_q;
        2'd2:    bus_rdata[2:0] = {ovr_q, rx_valid_q, busy};
        2'd3:    bus_rdata[7:0] = div_q;
        default: bus_rdata = '0;
      endcase
    end
  end

  assign irq = rx_valid_q;

endmodule

// File: doc/spi_master_mmio.md
Name: spi_master_mmio

Overview:
- Memory-mapped SPI master that sits directly downstream of the single-cycle CPU's data port, in the same address decode slot as the existing fake SPI model.
- The CPU writes a byte to TXDATA, which starts a Mode-0, MSB-first, 8-bit full-duplex transfer on the SPI pins. Software polls STATUS and reads the received byte from RXDATA.
- Register reads are combinational, so `lw` completes in one CPU cycle.

Parameters:
- W_CPU, 32, CPU data/address width.
- BASE_ADDR, 32'h0000_1000, base address of the 16-byte register window.
- DIV_RST, 8'd3, reset value of DIV. SCLK half-period = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- bus_sel  in  1  CPU data access in progress this cycle.
- bus_we  in  1  1 = store, 0 = load (valid when bus_sel=1).
- bus_addr  in  W_CPU  byte address from the ALU output.
- bus_wdata  in  W_CPU  store data (rd2).
- bus_rdata  out  W_CPU  load data. Combinational. 0 when not selected or unmapped.
- spi_sclk  out  1  SPI clock, idle low (CPOL=0).
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.
- spi_cs_n  out  1  chip select, active low.
- irq  out  1  level, equals rx_valid.

Behaviour:
- Register hit: bus_sel=1 and bus_addr[W_CPU-1:4]==BASE_ADDR[W_CPU-1:4]. Offset = bus_addr[3:2]. bus_addr[1:0] is ignored.
- Register map:
  - 0x0 TXDATA (W): bits[7:0]. Write when idle starts a transfer. Reads return 0.
  - 0x4 RXDATA (R): bits[7:0] = last received byte, zero-extended. A read clears rx_valid.
  - 0x8 STATUS (R): bit0 busy, bit1 rx_valid, bit2 ovr. A read clears ovr.
  - 0xC DIV (RW): bits[7:0].
- Reset values: state IDLE, spi_sclk=0, spi_cs_n=1, spi_mosi=0, busy=0, rx_valid=0, ovr=0, RXDATA=0, DIV=DIV_RST, irq=0.
- A reset asserted mid-transfer aborts immediately: CS deasserts the next edge and no RX update occurs.
- State machine. h = DIV+1 cycles; a half-period counter counts h.
  - IDLE: a TXDATA write loads the shift register with wdata[7:0], latches DIV into an internal copy, and moves to SETUP. busy=1 from the following cycle.
  - SETUP: cs_n=0, mosi=bit7, sclk=0. After h cycles, go to XFER.
  - XFER: 16 half-periods.
    - On the rising sclk edge (odd half-periods), sample miso into the shift LSB side.
    - On the falling edge, shift: mosi = next bit.
    - After the 16th half-period, sclk=0; go to HOLD.
  - HOLD: cs_n=0, sclk=0 for h cycles. Then IDLE: cs_n=1, busy=0, RXDATA=received byte, rx_valid=1, all in the same cycle.
  - Total busy = 18h cycles.
- A DIV write while busy updates the register but not the active transfer, which uses the latched copy.
- A TXDATA write while busy is ignored (shift register untouched) and sets ovr=1 (sticky).
- ovr set and STATUS read in the same cycle: set wins.
- rx_valid: a completion in the same cycle as an RXDATA read leaves rx_valid=1 and the read returns the old RXDATA. A new completion while rx_valid=1 overwrites RXDATA; ovr is not set.
- Bus reads have no side effects unless bus_sel=1 and bus_we=0.
- Stores to RXDATA and STATUS are ignored.

Test Plan:
- Reset, then read the four offsets -> TXDATA=0, RXDATA=0, STATUS=0, DIV=3. Pins: cs_n=1, sclk=0.
- DIV=1, miso tied to mosi, store 0xA5 -> cs_n low for 36 cycles, 8 sclk pulses each 2 high / 2 low, mosi bits 1,0,1,0,0,1,0,1. Then STATUS=0x2, RXDATA=0x000000A5, irq=1. A following STATUS read returns 0x0 (rx_valid cleared by the RXDATA read).
- Slave model drives 0x3C on miso, store 0xFF with DIV=0 -> busy exactly 18 cycles, RXDATA=0x3C.
- Store 0x11, then store 0x22 mid-transfer -> the transfer sends 0x11 only, STATUS bit2=1. Next STATUS read clears ovr.
- Write DIV=7 mid-transfer -> current transfer keeps the old half-period. The next transfer has an 8-cycle half-period.
- Assert rst halfway through a transfer -> the next cycle shows cs_n=1, sclk=0, STATUS=0, RXDATA unchanged from its reset value 0.
